// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: drives a req/ack data bus, stalls the
// pipeline until the access completes, and formats load results.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enM,
    input  logic        mem_weM,
    input  logic [1:0]  mem_sizeM,
    input  logic        mem_unsM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    output logic [31:0] readdataM,
    output logic        mem_stall,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rd_q, rd_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic        misalign;
    logic        go;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign misalign = mem_enM &
        (((mem_sizeM == 2'b01) & addrM[0]) |
         (mem_sizeM[1] & (addrM[1:0] != 2'b00)));
    assign go        = mem_enM & ~misalign;
    assign adel      = misalign & ~mem_weM;
    assign ades      = misalign & mem_weM;
    assign mem_stall = go & (state_q != S_DONE);

    always_comb begin
        be_new = 4'b1111;
        wd_new = wdataM;
        unique case (1'b1)
            (mem_sizeM == 2'b00): begin
                be_new = 4'b0001 << addrM[1:0];
                wd_new = {4{wdataM[7:0]}};
            end
            (mem_sizeM == 2'b01): begin
                be_new = addrM[1] ? 4'b1100 : 4'b0011;
                wd_new = {2{wdataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset captured at issue, not the live address.
    always_comb begin
        ld_byte = bus_rdata[7:0];
        unique case (off_q)
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            2'd3:    ld_byte = bus_rdata[31:24];
            default: ld_byte = bus_rdata[7:0];
        endcase
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (1'b1)
            (size_q == 2'b00):
                ld_fmt = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            (size_q == 2'b01):
                ld_fmt = {{16{~uns_q & ld_half[15]}}, ld_half};
            default:
                ld_fmt = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        err_d   = 1'b0;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    addr_d  = {addrM[31:2], 2'b00};
                    we_d    = mem_weM;
                    be_d    = be_new;
                    wd_d    = wd_new;
                    off_d   = addrM[1:0];
                    size_d  = mem_sizeM;
                    uns_d   = mem_unsM;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_ack) begin
                    req_d   = 1'b0;
                    if (!we_q) rd_d = ld_fmt;
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_MAX)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rd_d    = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    assign readdataM = rd_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wd_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model predicts every cycle,
// directed cases pin the model, then randomized traffic.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_enM, mem_weM, mem_unsM;
    logic [1:0]  mem_sizeM;
    logic [31:0] addrM, wdataM;
    logic [31:0] readdataM;
    logic        mem_stall, adel, ades, bus_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_enM(mem_enM), .mem_weM(mem_weM),
        .mem_sizeM(mem_sizeM), .mem_unsM(mem_unsM),
        .addrM(addrM), .wdataM(wdataM),
        .readdataM(readdataM), .mem_stall(mem_stall),
        .adel(adel), .ades(ades), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0;
    logic [31:0] m_rd = '0;
    logic [31:0] e_rd = '0, e_addr = '0, e_wd = '0;
    logic [3:0]  e_be = '0;
    logic        e_stall = 0, e_adel = 0, e_ades = 0;
    logic        e_err = 0, e_req = 0, e_we = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("readdataM", readdataM, e_rd);
            chk("mem_stall", 32'(mem_stall), 32'(e_stall));
            chk("adel", 32'(adel), 32'(e_adel));
            chk("ades", 32'(ades), 32'(e_ades));
            chk("bus_err", 32'(bus_err), 32'(e_err));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            if (e_req) begin
                chk("bus_we", 32'(bus_we), 32'(e_we));
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_be", 32'(bus_be), 32'(e_be));
                chk("bus_wdata", bus_wdata, e_wd);
            end
        end
    end

    function automatic logic [31:0] fmt(logic [1:0] sz, logic uns,
                                        logic [1:0] off, logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (8 * (off & 2'b10))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic cyc(inout int s);
        @(negedge clk);
        s += int'(mem_stall);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic en, input logic we,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ackdly, input logic [31:0] rdv,
                          output int stalls);
        logic mis, tmo;
        int   n;
        mis = en && ((sz == 2'b01 && a[0]) ||
                     (sz[1] && a[1:0] != 2'b00));
        mem_enM = en; mem_weM = we; mem_sizeM = sz;
        mem_unsM = uns; addrM = a; wdataM = wd;
        stalls = 0;
        e_rd = m_rd; e_err = 0;
        e_adel = mis && !we; e_ades = mis && we;
        e_req = 0;
        bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
        if (!en || mis) begin
            e_stall = 0;
            cyc(stalls);
            return;
        end
        e_stall = 1;
        cyc(stalls);
        tmo = (ackdly >= TMO);
        n = tmo ? TMO : ackdly + 1;
        e_req = 1; e_we = we; e_addr = {a[31:2], 2'b00};
        if (sz == 2'b00) begin
            e_be = 4'(1 << a[1:0]);
            e_wd = 32'h0101_0101 * wd[7:0];
        end else if (sz == 2'b01) begin
            e_be = 4'(3 << (a[1:0] & 2'b10));
            e_wd = 32'h0001_0001 * wd[15:0];
        end else begin
            e_be = 4'hF;
            e_wd = wd;
        end
        for (int i = 0; i < n; i++) begin
            bus_ack = (i == ackdly);
            bus_rdata = (i == ackdly) ? rdv : $urandom;
            cyc(stalls);
        end
        if (tmo) m_rd = '0;
        else if (!we) m_rd = fmt(sz, uns, a[1:0], rdv);
        e_rd = m_rd; e_stall = 0; e_req = 0; e_err = tmo;
        bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
        cyc(stalls);
        e_err = 0;
    endtask

    initial begin
        int st, dly;
        logic [31:0] r, a;
        rst = 1; mem_enM = 0; mem_weM = 0; mem_sizeM = 0; mem_unsM = 0;
        addrM = 0; wdataM = 0; bus_ack = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_readdataM", readdataM, 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk_en = 1;

        run_op(1, 0, 2'b10, 0, 32'h100, 0, 2, 32'hDEADBEEF, st);
        chk("lw_rd", readdataM, 32'hDEADBEEF);
        chk("lw_stalls", 32'(st), 32'd4);
        run_op(1, 0, 2'b00, 0, 32'h103, 0, 0, 32'h80FF1234, st);
        chk("lb_rd", readdataM, 32'hFFFFFF80);
        chk("lb_be", 32'(bus_be), 32'h8);
        run_op(1, 0, 2'b00, 1, 32'h103, 0, 1, 32'h80FF1234, st);
        chk("lbu_rd", readdataM, 32'h00000080);
        run_op(1, 0, 2'b01, 0, 32'h102, 0, 0, 32'h80FF1234, st);
        chk("lh_rd", readdataM, 32'hFFFF80FF);

        mem_enM = 1; mem_weM = 0; mem_sizeM = 2'b10; addrM = 32'h400;
        bus_ack = 0; e_stall = 1; e_req = 0; e_rd = m_rd;
        cyc(st);
        e_req = 1; e_we = 0; e_addr = 32'h400; e_be = 4'hF; e_wd = wdataM;
        cyc(st);
        rst = 1;
        cyc(st);
        rst = 0; mem_enM = 0; m_rd = '0;
        e_rd = 0; e_req = 0; e_stall = 0;
        cyc(st);
        bus_ack = 1; bus_rdata = 32'h12345678;
        cyc(st);
        bus_ack = 0;
        cyc(st);
        chk("rstmid_rd", readdataM, 32'h0);
        chk("rstmid_req", 32'(bus_req), 32'h0);

        run_op(1, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 0, 0, st);
        chk("sh_stalls", 32'(st), 32'd2);
        chk("sh_wdata", bus_wdata, 32'hABCDABCD);
        chk("sh_addr", bus_addr, 32'h200);
        run_op(1, 0, 2'b10, 0, 32'h102, 0, 0, 0, st);
        chk("lw_mis_stalls", 32'(st), 32'd0);
        run_op(1, 1, 2'b10, 0, 32'h101, 32'h55, 0, 0, st);
        run_op(1, 1, 2'b00, 0, 32'h101, 32'h5A, 0, 0, st);
        chk("sb_be", 32'(bus_be), 32'h2);
        run_op(1, 0, 2'b10, 0, 32'h100, 0, 0, 32'hDEADBEEF, st);
        run_op(1, 0, 2'b10, 0, 32'h300, 0, 99, 0, st);
        chk("tmo_stalls", 32'(st), 32'd5);
        chk("tmo_rd", readdataM, 32'h0);

        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            a = $urandom;
            if (r[3:2] != 2'b00) a[1:0] = r[3:2] == 2'b01 ? 2'b00 : {a[1], 1'b0};
            dly = $urandom_range(0, 5);
            run_op(r[9:5] != 5'd0, r[10], r[12:11], r[13], a,
                   $urandom, dly, $urandom, st);
        end

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
